// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stalls, squashes, freezes, forwarding.
// Optional performance counters are enabled with `define HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned RAW = 5
`ifdef HAZ_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           id_valid,
  input  logic [RAW-1:0] id_rs1,
  input  logic [RAW-1:0] id_rs2,
  input  logic           id_use_rs1,
  input  logic           id_use_rs2,
  input  logic [RAW-1:0] id_rd,
  input  logic           id_regwrite,
  input  logic           id_memread,
  input  logic           id_memwrite,
  input  logic           ex_branch_taken,
  input  logic           dmem_ready,
  output logic           pc_en,
  output logic           if_di_en,
  output logic           di_ex_en,
  output logic           ex_me_en,
  output logic           me_wb_en,
  output logic           if_di_flush,
  output logic           di_ex_flush,
  output logic [1:0]     fwd_a,
  output logic [1:0]     fwd_b
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
`endif
);

  typedef enum logic [1:0] {HzNormal, HzLoadUse, HzBranch, HzFreeze} haz_e;

  logic           ex_valid_q, ex_regwrite_q, ex_memread_q, ex_memaccess_q;
  logic [RAW-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
  logic           me_valid_q, me_regwrite_q, me_memread_q, me_memaccess_q;
  logic [RAW-1:0] me_rd_q;
  logic           wb_valid_q, wb_regwrite_q;
  logic [RAW-1:0] wb_rd_q;

  haz_e haz;
  logic freeze, branch, load_use;
  logic me_fwd_ok, wb_fwd_ok;

  always_comb begin
    freeze   = me_valid_q & me_memaccess_q & ~dmem_ready;
    branch   = ex_valid_q & ex_branch_taken;
    load_use = id_valid & ex_valid_q & ex_memread_q & (ex_rd_q != '0) &
               ((id_use_rs1 & (id_rs1 == ex_rd_q)) | (id_use_rs2 & (id_rs2 == ex_rd_q)));
    if (freeze)        haz = HzFreeze;
    else if (branch)   haz = HzBranch;
    else if (load_use) haz = HzLoadUse;
    else               haz = HzNormal;
  end

  always_comb begin
    pc_en       = 1'b1;
    if_di_en    = 1'b1;
    di_ex_en    = 1'b1;
    ex_me_en    = 1'b1;
    me_wb_en    = 1'b1;
    if_di_flush = 1'b0;
    di_ex_flush = 1'b0;
    unique case (haz)
      HzFreeze: begin
        pc_en    = 1'b0;
        if_di_en = 1'b0;
        di_ex_en = 1'b0;
        ex_me_en = 1'b0;
        me_wb_en = 1'b0;
      end
      HzBranch: begin
        if_di_flush = 1'b1;
        di_ex_flush = 1'b1;
      end
      HzLoadUse: begin
        pc_en       = 1'b0;
        if_di_en    = 1'b0;
        di_ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  // Loads in ME are never forwarded; the load-use bubble puts them in WB first.
  always_comb begin
    me_fwd_ok = me_valid_q & me_regwrite_q & ~me_memread_q & (me_rd_q != '0);
    wb_fwd_ok = wb_valid_q & wb_regwrite_q & (wb_rd_q != '0);
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (me_fwd_ok && (me_rd_q == ex_rs1_q))      fwd_a = 2'b01;
    else if (wb_fwd_ok && (wb_rd_q == ex_rs1_q)) fwd_a = 2'b10;
    if (me_fwd_ok && (me_rd_q == ex_rs2_q))      fwd_b = 2'b01;
    else if (wb_fwd_ok && (wb_rd_q == ex_rs2_q)) fwd_b = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_valid_q     <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      ex_memaccess_q <= 1'b0;
      ex_rd_q        <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      me_valid_q     <= 1'b0;
      me_regwrite_q  <= 1'b0;
      me_memread_q   <= 1'b0;
      me_memaccess_q <= 1'b0;
      me_rd_q        <= '0;
      wb_valid_q     <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_rd_q        <= '0;
    end else begin
      if (di_ex_en) begin
        ex_valid_q     <= id_valid & ~di_ex_flush;
        ex_regwrite_q  <= id_regwrite & ~di_ex_flush;
        ex_memread_q   <= id_memread & ~di_ex_flush;
        ex_memaccess_q <= (id_memread | id_memwrite) & ~di_ex_flush;
        ex_rd_q        <= di_ex_flush ? '0 : id_rd;
        ex_rs1_q       <= di_ex_flush ? '0 : id_rs1;
        ex_rs2_q       <= di_ex_flush ? '0 : id_rs2;
      end
      if (ex_me_en) begin
        me_valid_q     <= ex_valid_q;
        me_regwrite_q  <= ex_regwrite_q;
        me_memread_q   <= ex_memread_q;
        me_memaccess_q <= ex_memaccess_q;
        me_rd_q        <= ex_rd_q;
      end
      if (me_wb_en) begin
        wb_valid_q    <= me_valid_q;
        wb_regwrite_q <= me_regwrite_q;
        wb_rd_q       <= me_rd_q;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (haz == HzLoadUse && stall_cnt != '1) stall_cnt  <= stall_cnt + CNT_W'(1);
      if (haz == HzBranch && flush_cnt != '1)  flush_cnt  <= flush_cnt + CNT_W'(1);
      if (haz == HzFreeze && freeze_cnt != '1) freeze_cnt <= freeze_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed program snippets then random traffic vs a stage model.
// Also checks the counters when built with HAZ_PERF_CNT_EN (counter width 2 to hit saturation).
module tb_pipeline_hazard_ctrl;
  localparam int unsigned RAW = 5;
`ifdef HAZ_PERF_CNT_EN
  localparam int unsigned CNT_W = 2;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
  int m_stall, m_flush, m_freeze;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n, id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, id_memwrite;
  logic [RAW-1:0] id_rs1, id_rs2, id_rd;
  logic           ex_branch_taken, dmem_ready;
  logic           pc_en, if_di_en, di_ex_en, ex_me_en, me_wb_en, if_di_flush, di_ex_flush;
  logic [1:0]     fwd_a, fwd_b;

  int n_checks = 0;
  int n_pass = 0;

  // One record per in-flight instruction; p[0]=EX, p[1]=ME, p[2]=WB.
  typedef struct packed {
    logic           v;
    logic [RAW-1:0] rd;
    logic           wr;
    logic           ld;
    logic           mem;
    logic [RAW-1:0] rs1;
    logic [RAW-1:0] rs2;
  } ins_t;
  ins_t p [3];

  pipeline_hazard_ctrl #(
    .RAW(RAW)
`ifdef HAZ_PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready), .pc_en(pc_en),
    .if_di_en(if_di_en), .di_ex_en(di_ex_en), .ex_me_en(ex_me_en), .me_wb_en(me_wb_en),
    .if_di_flush(if_di_flush), .di_ex_flush(di_ex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // 0 normal, 1 load-use, 2 branch, 3 freeze
  function automatic int winner();
    if (p[1].v && p[1].mem && !dmem_ready) return 3;
    if (p[0].v && ex_branch_taken) return 2;
    if (id_valid && p[0].v && p[0].ld && p[0].rd != 0 &&
        ((id_use_rs1 && id_rs1 == p[0].rd) || (id_use_rs2 && id_rs2 == p[0].rd))) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] fwd(input logic [RAW-1:0] rs);
    if (p[1].v && p[1].wr && !p[1].ld && p[1].rd != 0 && p[1].rd == rs) return 2'b01;
    if (p[2].v && p[2].wr && p[2].rd != 0 && p[2].rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Called after inputs settle: check against the model, then clock the model with the DUT.
  task automatic cycle();
    int w;
    logic [4:0] exp_en;
    logic [1:0] exp_fl;
    ins_t din;
    w = winner();
    case (w)
      3:       begin exp_en = 5'b00000; exp_fl = 2'b00; end
      2:       begin exp_en = 5'b11111; exp_fl = 2'b11; end
      1:       begin exp_en = 5'b00111; exp_fl = 2'b01; end
      default: begin exp_en = 5'b11111; exp_fl = 2'b00; end
    endcase
    chk("enables", {27'd0, pc_en, if_di_en, di_ex_en, ex_me_en, me_wb_en}, {27'd0, exp_en});
    chk("flushes", {30'd0, if_di_flush, di_ex_flush}, {30'd0, exp_fl});
    chk("fwd_a", {30'd0, fwd_a}, {30'd0, fwd(p[0].rs1)});
    chk("fwd_b", {30'd0, fwd_b}, {30'd0, fwd(p[0].rs2)});
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    chk("freeze_cnt", 32'(freeze_cnt), 32'(m_freeze));
`endif
    din = '{v: id_valid, rd: id_rd, wr: id_regwrite, ld: id_memread,
            mem: id_memread | id_memwrite, rs1: id_rs1, rs2: id_rs2};
    @(posedge clk);
    if (!reset_n) begin
      p[0] = '0; p[1] = '0; p[2] = '0;
`ifdef HAZ_PERF_CNT_EN
      m_stall = 0; m_flush = 0; m_freeze = 0;
`endif
    end else begin
`ifdef HAZ_PERF_CNT_EN
      if (w == 1 && m_stall < 3) m_stall++;
      if (w == 2 && m_flush < 3) m_flush++;
      if (w == 3 && m_freeze < 3) m_freeze++;
`endif
      if (w != 3) begin
        p[2] = p[1];
        p[1] = p[0];
        p[0] = (w != 0) ? '0 : din;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input int rs1, input logic u1, input int rs2,
                        input logic u2, input int rd, input logic wr, input logic ld,
                        input logic st);
    id_valid = v; id_rs1 = RAW'(rs1); id_use_rs1 = u1; id_rs2 = RAW'(rs2); id_use_rs2 = u2;
    id_rd = RAW'(rd); id_regwrite = wr; id_memread = ld; id_memwrite = st;
    #1;
  endtask

  task automatic idle(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) cycle();
  endtask

  initial begin
    reset_n = 1'b0; ex_branch_taken = 1'b0; dmem_ready = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    p[0] = '0; p[1] = '0; p[2] = '0;
`ifdef HAZ_PERF_CNT_EN
    m_stall = 0; m_flush = 0; m_freeze = 0;
`endif
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_pc_en", 32'(pc_en), 32'd1);
    chk("reset_fwd_a", 32'(fwd_a), 32'd0);
    cycle();
    reset_n = 1'b1;
    idle(2);

    // lw x5,0(x1); add x6,x5,x2
    set_id(1, 1, 1, 0, 0, 5, 1, 1, 0); cycle();
    set_id(1, 5, 1, 2, 1, 6, 1, 0, 0);
    chk("lu_pc_en", 32'(pc_en), 32'd0);
    chk("lu_if_di_en", 32'(if_di_en), 32'd0);
    chk("lu_di_ex_flush", 32'(di_ex_flush), 32'd1);
    cycle();
    chk("lu_resume_pc_en", 32'(pc_en), 32'd1);
    cycle();
    idle(0);
    chk("lu_fwd_a_wb", 32'(fwd_a), 32'd2);
    chk("lu_fwd_b", 32'(fwd_b), 32'd0);
    idle(3);

    // add x3,x1,x2; sub x4,x3,x3
    set_id(1, 1, 1, 2, 1, 3, 1, 0, 0); cycle();
    set_id(1, 3, 1, 3, 1, 4, 1, 0, 0);
    chk("alu_no_stall", 32'(pc_en), 32'd1);
    cycle();
    idle(0);
    chk("alu_fwd_a_me", 32'(fwd_a), 32'd1);
    chk("alu_fwd_b_me", 32'(fwd_b), 32'd1);
    idle(3);

    // taken branch in EX
    set_id(1, 1, 1, 2, 1, 0, 0, 0, 0); cycle();
    set_id(1, 7, 1, 7, 1, 8, 1, 0, 0);
    ex_branch_taken = 1'b1; #1;
    chk("br_if_di_flush", 32'(if_di_flush), 32'd1);
    chk("br_di_ex_flush", 32'(di_ex_flush), 32'd1);
    chk("br_pc_en", 32'(pc_en), 32'd1);
    cycle();
    ex_branch_taken = 1'b0; #1;
    chk("br_after_flush", 32'(di_ex_flush), 32'd0);
    idle(3);

    // sw stalls in ME for three cycles
    set_id(1, 1, 1, 2, 1, 0, 0, 0, 1); cycle();
    idle(1);
    dmem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("frz_enables", {27'd0, pc_en, if_di_en, di_ex_en, ex_me_en, me_wb_en}, 32'd0);
      cycle();
    end
    dmem_ready = 1'b1; #1;
    chk("frz_release", 32'(me_wb_en), 32'd1);
    idle(3);

    // addi x0,x0,5; add x7,x0,x0
    set_id(1, 0, 1, 0, 0, 0, 1, 0, 0); cycle();
    set_id(1, 0, 1, 0, 1, 7, 1, 0, 0); cycle();
    idle(0);
    chk("x0_fwd_a", 32'(fwd_a), 32'd0);
    chk("x0_fwd_b", 32'(fwd_b), 32'd0);
    idle(3);

    // reset during a freeze
    set_id(1, 1, 1, 0, 0, 9, 1, 1, 0); cycle();
    idle(1);
    dmem_ready = 1'b0; #1;
    chk("rst_frz_pc_en", 32'(pc_en), 32'd0);
    cycle();
    reset_n = 1'b0; #1;
    cycle();
    reset_n = 1'b1; #1;
    chk("rst_frz_after", 32'(pc_en), 32'd1);
    dmem_ready = 1'b1; #1;
    idle(2);

    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      dmem_ready = ($urandom_range(0, 3) != 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      set_id(($urandom_range(0, 5) != 0), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 5) == 0));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
